// File: rtl/riscv_defs.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_defs : opcodes, bypass encodings and hazard slot types     |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
package riscv_defs;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BCC   = 7'b1100011;
  localparam logic [6:0] LCC   = 7'b0000011;
  localparam logic [6:0] SCC   = 7'b0100011;
  localparam logic [6:0] MCC   = 7'b0010011;
  localparam logic [6:0] RCC   = 7'b0110011;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] MX   = 2'b01;
  localparam logic [1:0] WX   = 2'b10;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       is_load;
    logic       is_store;
  } dec_t;

  typedef struct packed {
    logic valid;
    dec_t d;
  } slot_t;

  function automatic logic fwd_hit(input slot_t s, input logic [4:0] r);
    return s.valid && s.d.writes_rd && (s.d.rd == r);
  endfunction

  // The younger producer in M always wins over the older one in W.
  function automatic logic [1:0] sel_bypass(input logic use_rs, input logic [4:0] rs,
                                            input slot_t mem, input slot_t wb);
    if (!use_rs)               return NONE;
    else if (fwd_hit(mem, rs)) return MX;
    else if (fwd_hit(wb, rs))  return WX;
    else                       return NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hz_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hz_decode : register-usage classification of one instruction     |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
module hz_decode
  import riscv_defs::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0] w_opcode;
  logic       unused_bits;

  assign w_opcode    = inst[6:0];
  assign unused_bits = ^{inst[31:25], inst[14:12]};

  always_comb begin
    dec          = '0;
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.rd       = inst[11:7];
    dec.uses_rs1 = !((w_opcode == LUI) || (w_opcode == AUIPC) || (w_opcode == JAL));
    dec.uses_rs2 = (w_opcode == RCC) || (w_opcode == BCC) || (w_opcode == SCC);
    // x0 is never a producer, so it can never forward or stall.
    dec.writes_rd = !((w_opcode == BCC) || (w_opcode == SCC)) && (inst[11:7] != 5'd0);
    dec.is_load  = (w_opcode == LCC);
    dec.is_store = (w_opcode == SCC);
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctl : forwarding, load-use stall and branch flush control |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
module hazard_ctl
  import riscv_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_d,
  input  logic        inst_valid_d,
  input  logic        pc_sel_x,
  output logic [1:0]  alu_in1_bypass,
  output logic [1:0]  alu_in2_bypass,
  output logic        wm_bypass,
  output logic        wd_rs1,
  output logic        wd_rs2,
  output logic        stall_fd,
  output logic        flush_d,
  output logic        flush_x
);

  dec_t  w_dec;
  slot_t r_ex, r_mem, r_wb;
  slot_t w_ex_next;
  logic  w_load_use;
  logic  w_redirect;

  hz_decode u_decode (
    .inst (inst_d),
    .dec  (w_dec)
  );

  // Store data is patched in M from W, so a load feeding only store rs2 needs no stall.
  assign w_load_use = r_ex.valid && r_ex.d.is_load && r_ex.d.writes_rd && inst_valid_d &&
                      ((w_dec.uses_rs1 && (r_ex.d.rd == w_dec.rs1)) ||
                       (w_dec.uses_rs2 && !w_dec.is_store && (r_ex.d.rd == w_dec.rs2)));
  assign w_redirect = pc_sel_x & rst_n;

  assign stall_fd = w_load_use & ~w_redirect;
  assign flush_d  = w_redirect;
  assign flush_x  = w_load_use | w_redirect;

  assign alu_in1_bypass = sel_bypass(r_ex.valid && r_ex.d.uses_rs1, r_ex.d.rs1, r_mem, r_wb);
  assign alu_in2_bypass = sel_bypass(r_ex.valid && r_ex.d.uses_rs2, r_ex.d.rs2, r_mem, r_wb);
  assign wm_bypass      = r_mem.valid && r_mem.d.is_store && fwd_hit(r_wb, r_mem.d.rs2);
  assign wd_rs1         = w_dec.uses_rs1 && fwd_hit(r_wb, inst_d[19:15]);
  assign wd_rs2         = w_dec.uses_rs2 && fwd_hit(r_wb, inst_d[24:20]);

  always_comb begin
    w_ex_next = '0;
    if (inst_valid_d && !stall_fd && !flush_x) begin
      w_ex_next.valid = 1'b1;
      w_ex_next.d     = w_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= w_ex_next;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hazard_ctl : scoreboard bench with a behavioural pipeline model |
// | Revision      : 1.0                                                |
// +------------------------------------------------------------------+
module tb_hazard_ctl;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_d;
  logic        inst_valid_d;
  logic        pc_sel_x;
  logic [1:0]  alu_in1_bypass, alu_in2_bypass;
  logic        wm_bypass, wd_rs1, wd_rs2, stall_fd, flush_d, flush_x;

  hazard_ctl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_d         (inst_d),
    .inst_valid_d   (inst_valid_d),
    .pc_sel_x       (pc_sel_x),
    .alu_in1_bypass (alu_in1_bypass),
    .alu_in2_bypass (alu_in2_bypass),
    .wm_bypass      (wm_bypass),
    .wd_rs1         (wd_rs1),
    .wd_rs2         (wd_rs2),
    .stall_fd       (stall_fd),
    .flush_d        (flush_d),
    .flush_x        (flush_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit r1, r2, wr, ld, st;
  } mi_t;

  typedef struct {
    int a1, a2, wm, wd1, wd2, st, fd, fx;
  } exp_t;

  int     checks   = 0;
  int     failures = 0;
  exp_t   sb_q[$];
  mi_t    mx, mm, mw, pend_x;
  logic [31:0] ins;
  logic [6:0]  ops [9];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic mi_t model_dec(input logic [31:0] i);
    mi_t r;
    logic [6:0] op;
    op    = i[6:0];
    r.v   = 1'b1;
    r.rd  = int'(i[11:7]);
    r.rs1 = int'(i[19:15]);
    r.rs2 = int'(i[24:20]);
    r.r1  = !(op inside {7'h37, 7'h17, 7'h6f});
    r.r2  = op inside {7'h33, 7'h63, 7'h23};
    r.wr  = !(op inside {7'h63, 7'h23}) && (r.rd != 0);
    r.ld  = (op == 7'h03);
    r.st  = (op == 7'h23);
    return r;
  endfunction

  function automatic bit produces(input mi_t s, input int r);
    return s.v && s.wr && (s.rd == r);
  endfunction

  function automatic int src_sel(input bit use_it, input int r);
    if (!mx.v || !use_it) return 0;
    if (produces(mm, r))  return 1;
    if (produces(mw, r))  return 2;
    return 0;
  endfunction

  task automatic model_reset();
    mx = '{default: 0};
    mm = '{default: 0};
    mw = '{default: 0};
    pend_x = '{default: 0};
  endtask

  task automatic drive(input logic [31:0] i, input bit v, input bit pc);
    mi_t  d;
    exp_t e;
    bit   lu;
    inst_d = i; inst_valid_d = v; pc_sel_x = pc;
    d = model_dec(i);
    lu = mx.v && mx.ld && mx.wr && v &&
         ((d.r1 && mx.rd == d.rs1) || (d.r2 && !d.st && mx.rd == d.rs2));
    e.a1  = src_sel(mx.r1, mx.rs1);
    e.a2  = src_sel(mx.r2, mx.rs2);
    e.wm  = int'(mm.v && mm.st && produces(mw, mm.rs2));
    e.wd1 = int'(d.r1 && produces(mw, d.rs1));
    e.wd2 = int'(d.r2 && produces(mw, d.rs2));
    e.st  = int'(lu && !pc);
    e.fd  = int'(pc);
    e.fx  = int'(lu || pc);
    sb_q.push_back(e);
    pend_x = (v && !lu && !pc) ? d : '{default: 0};
  endtask

  task automatic adv();
    @(posedge clk);
    mw = mm; mm = mx; mx = pend_x;
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_a1"}, int'(alu_in1_bypass), 0);
    chk({tag, "_a2"}, int'(alu_in2_bypass), 0);
    chk({tag, "_wm"}, int'(wm_bypass), 0);
    chk({tag, "_wd1"}, int'(wd_rs1), 0);
    chk({tag, "_wd2"}, int'(wd_rs2), 0);
    chk({tag, "_stall"}, int'(stall_fd), 0);
    chk({tag, "_fd"}, int'(flush_d), 0);
    chk({tag, "_fx"}, int'(flush_x), 0);
  endtask

  function automatic logic [31:0] r_op(input int rd, input int rs1, input int rs2);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] lw_op(input int rd, input int rs1);
    return {12'd0, rs1[4:0], 3'b010, rd[4:0], 7'h03};
  endfunction
  function automatic logic [31:0] sw_op(input int rs2, input int rs1);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b010, 5'd0, 7'h23};
  endfunction
  function automatic logic [31:0] addi_op(input int rd, input int rs1);
    return {12'd1, rs1[4:0], 3'b000, rd[4:0], 7'h13};
  endfunction

  // Monitor: compare whatever the DUT shows against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("alu_in1_bypass", int'(alu_in1_bypass), e.a1);
        chk("alu_in2_bypass", int'(alu_in2_bypass), e.a2);
        chk("wm_bypass", int'(wm_bypass), e.wm);
        chk("wd_rs1", int'(wd_rs1), e.wd1);
        chk("wd_rs2", int'(wd_rs2), e.wd2);
        chk("stall_fd", int'(stall_fd), e.st);
        chk("flush_d", int'(flush_d), e.fd);
        chk("flush_x", int'(flush_x), e.fx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    rst_n = 1'b0; inst_d = '0; inst_valid_d = 1'b0; pc_sel_x = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // MX then WX forwarding of x5
    drive(r_op(5, 1, 2), 1, 0); adv();
    drive(r_op(6, 5, 3), 1, 0); adv();
    drive(r_op(7, 5, 0), 1, 0); #1 chk("dir_mx", int'(alu_in1_bypass), 1); adv();
    drive(r_op(12, 0, 0), 1, 0); #1 chk("dir_wx", int'(alu_in1_bypass), 2); adv();

    // load-use: one stall cycle, then WX on both operands
    drive(lw_op(7, 1), 1, 0); adv();
    drive(r_op(8, 7, 7), 1, 0); #1 chk("lu_stall", int'(stall_fd), 1); adv();
    drive(r_op(8, 7, 7), 1, 0); #1 chk("lu_once", int'(stall_fd), 0); adv();
    drive(r_op(0, 0, 0), 1, 0);
    #1 chk("lu_a1", int'(alu_in1_bypass), 2); chk("lu_a2", int'(alu_in2_bypass), 2); adv();

    // x0 never forwards
    drive(addi_op(0, 0), 1, 0); adv();
    drive(r_op(9, 0, 0), 1, 0); adv();
    drive(r_op(0, 0, 0), 1, 0);
    #1 chk("x0_a1", int'(alu_in1_bypass), 0); chk("x0_a2", int'(alu_in2_bypass), 0); adv();

    // branch redirect overrides load-use stall
    drive(lw_op(7, 1), 1, 0); adv();
    drive(r_op(8, 7, 7), 1, 1);
    #1 chk("br_fd", int'(flush_d), 1); chk("br_fx", int'(flush_x), 1);
    chk("br_stall", int'(stall_fd), 0); adv();

    // load feeding store data: no stall, W->M patch
    drive(lw_op(4, 2), 1, 0); adv();
    drive(sw_op(4, 3), 1, 0); #1 chk("ls_nostall", int'(stall_fd), 0); adv();
    drive(r_op(0, 0, 0), 1, 0); adv();
    drive(r_op(0, 0, 0), 1, 0); #1 chk("ls_wm", int'(wm_bypass), 1); adv();

    // reset asserted mid-stall
    drive(lw_op(7, 1), 1, 0); adv();
    drive(r_op(8, 7, 7), 1, 0); #1 chk("rs_stall", int'(stall_fd), 1);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 check_idle("rst_mid");
    inst_valid_d = 1'b0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    drive(r_op(9, 7, 8), 1, 0); adv();
    drive(r_op(10, 9, 7), 1, 0);
    #1 chk("post_rst_a1", int'(alu_in1_bypass), 0); chk("post_rst_a2", int'(alu_in2_bypass), 0); adv();

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 8)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      drive(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0);
      adv();
    end

    @(negedge clk); #1;
    chk("queue_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
